// File: rtl/health_tracker.sv
// ---------------------------------------------------------------------------
// health_tracker
//   Player health and lives tracker for the space shooter. It accepts hit
//   (variable damage) and heal (+1) events on the frame strobe. It also keeps
//   a lives reserve, opens a post-hit invulnerability window, and raises a
//   sticky death flag when the last life is gone. Health is shown on two
//   7-segment digits.
//
//   Ports:
//     clk        system clock
//     reset      synchronous active-high reset
//     tick       frame-update strobe; hit/heal are only seen when it is high
//     restart    game-over restart; same effect as reset
//     hit        collision event, amount given on damage
//     damage     damage amount for hit (HEALTH_W bits)
//     heal       pickup event, +1 health (saturating at MAX_HEALTH)
//     health     current health
//     lives      lives remaining
//     invuln     high while hits are ignored
//     life_lost  one-cycle pulse when a life is consumed (not on death)
//     dead       sticky, no lives left
//     hex_ones   health ones digit, segment pattern from decoder7
//     hex_tens   health tens digit, segment pattern from decoder7
// ---------------------------------------------------------------------------
module health_tracker #(
    parameter int HEALTH_W     = 7,
    parameter int MAX_HEALTH   = 10,
    parameter int LIVES_W      = 3,
    parameter int START_LIVES  = 3,
    parameter int INVULN_TICKS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                restart,
    input  logic                hit,
    input  logic [HEALTH_W-1:0] damage,
    input  logic                heal,
    output logic [HEALTH_W-1:0] health,
    output logic [LIVES_W-1:0]  lives,
    output logic                invuln,
    output logic                life_lost,
    output logic                dead,
    output logic [6:0]          hex_ones,
    output logic [6:0]          hex_tens
);

    // Counter must hold INVULN_TICKS; keep at least one bit when disabled.
    localparam int CNT_W = (INVULN_TICKS < 2) ? 1 : $clog2(INVULN_TICKS + 1);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [HEALTH_W-1:0] health_q, health_d;
    logic [LIVES_W-1:0]  lives_q, lives_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                invuln_q, invuln_d;
    logic                dead_q, dead_d;
    logic                life_lost_q, life_lost_d;

    logic [HEALTH_W:0]   diff_s;
    logic                lethal_s;
    logic [HEALTH_W-1:0] heal_sat_s;
    logic [3:0]          tens_s;
    logic [3:0]          ones_s;

    // Damage arithmetic and saturating heal value.
    always_comb begin
        // One extra bit: a borrow (or a zero result) marks a lethal hit.
        diff_s   = {1'b0, health_q} - {1'b0, damage};
        lethal_s = diff_s[HEALTH_W] | (diff_s == {(HEALTH_W+1){1'b0}});
        if (health_q < HEALTH_W'(MAX_HEALTH)) begin
            heal_sat_s = health_q + HEALTH_W'(1);
        end else begin
            heal_sat_s = health_q;
        end
    end

    // Next-state logic for the ALIVE/INVULN/DEAD machine and its datapath.
    always_comb begin
        state_d     = state_q;
        health_d    = health_q;
        lives_d     = lives_q;
        cnt_d       = cnt_q;
        life_lost_d = 1'b0;
        case (state_q)
            ALIVE: begin
                if (tick && hit && (damage != HEALTH_W'(0))) begin
                    // Hit has priority over a heal on the same tick.
                    if (!lethal_s) begin
                        health_d = diff_s[HEALTH_W-1:0];
                        state_d  = (INVULN_TICKS > 0) ? INVULN : ALIVE;
                        cnt_d    = CNT_W'(INVULN_TICKS);
                    end else if (lives_q > LIVES_W'(1)) begin
                        lives_d     = lives_q - LIVES_W'(1);
                        health_d    = HEALTH_W'(MAX_HEALTH);
                        life_lost_d = 1'b1;
                        state_d     = (INVULN_TICKS > 0) ? INVULN : ALIVE;
                        cnt_d       = CNT_W'(INVULN_TICKS);
                    end else begin
                        lives_d  = LIVES_W'(0);
                        health_d = HEALTH_W'(0);
                        state_d  = DEAD;
                    end
                end else if (tick && heal) begin
                    health_d = heal_sat_s;
                end else begin
                    health_d = health_q;
                end
            end
            INVULN: begin
                // Hits are ignored here, including on the closing tick.
                if (tick) begin
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_d   = CNT_W'(0);
                        state_d = ALIVE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    if (heal) begin
                        health_d = heal_sat_s;
                    end else begin
                        health_d = health_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DEAD: begin
                state_d = DEAD;
            end
            default: begin
                // Unreachable encoding: recover to a safe idle state.
                state_d = ALIVE;
                cnt_d   = CNT_W'(0);
            end
        endcase
        invuln_d = (state_d == INVULN);
        dead_d   = (state_d == DEAD);
    end

    // State and output registers; reset and restart override everything.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state_q     <= ALIVE;
            health_q    <= HEALTH_W'(MAX_HEALTH);
            lives_q     <= LIVES_W'(START_LIVES);
            cnt_q       <= CNT_W'(0);
            invuln_q    <= 1'b0;
            dead_q      <= 1'b0;
            life_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            health_q    <= health_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            invuln_q    <= invuln_d;
            dead_q      <= dead_d;
            life_lost_q <= life_lost_d;
        end
    end

    // Decimal split of the health register for the display.
    always_comb begin
        tens_s = 4'(health_q / HEALTH_W'(10));
        ones_s = 4'(health_q % HEALTH_W'(10));
    end

    assign health    = health_q;
    assign lives     = lives_q;
    assign invuln    = invuln_q;
    assign dead      = dead_q;
    assign life_lost = life_lost_q;

    decoder7 u_dec_ones (.digit(ones_s), .seg(hex_ones));
    decoder7 u_dec_tens (.digit(tens_s), .seg(hex_tens));

endmodule

// ---------------------------------------------------------------------------
// decoder7
//   BCD digit to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
//   Ports: digit (4-bit BCD in), seg (7-bit segment pattern out).
//   Non-decimal codes blank the digit.
// ---------------------------------------------------------------------------
module decoder7 (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Segment lookup.
    always_comb begin
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_health_tracker.sv
// ---------------------------------------------------------------------------
// tb_health_tracker
//   Directed test of health_tracker with default parameters (dut) and with
//   INVULN_TICKS=0, MAX_HEALTH=25, START_LIVES=1 (dut2).
// ---------------------------------------------------------------------------
module tb_health_tracker;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_4 = 7'b0011001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, restart = 1'b0, hit = 1'b0, heal = 1'b0;
    logic [6:0] damage = 7'd0;
    logic [6:0] health, hex_ones, hex_tens;
    logic [2:0] lives;
    logic       invuln, life_lost, dead;

    logic       tick2 = 1'b0, hit2 = 1'b0;
    logic [6:0] damage2 = 7'd0;
    logic [6:0] health2, hex_ones2, hex_tens2;
    logic [2:0] lives2;
    logic       invuln2, life_lost2, dead2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    health_tracker dut (
        .clk(clk), .reset(reset), .tick(tick), .restart(restart),
        .hit(hit), .damage(damage), .heal(heal),
        .health(health), .lives(lives), .invuln(invuln),
        .life_lost(life_lost), .dead(dead),
        .hex_ones(hex_ones), .hex_tens(hex_tens)
    );

    health_tracker #(.INVULN_TICKS(0), .MAX_HEALTH(25), .START_LIVES(1)) dut2 (
        .clk(clk), .reset(reset), .tick(tick2), .restart(1'b0),
        .hit(hit2), .damage(damage2), .heal(1'b0),
        .health(health2), .lives(lives2), .invuln(invuln2),
        .life_lost(life_lost2), .dead(dead2),
        .hex_ones(hex_ones2), .hex_tens(hex_tens2)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given events; outputs are sampled 1 ns after the edge.
    task automatic step(input logic t, input logic h, input logic [6:0] d, input logic hl);
        tick = t; hit = h; damage = d; heal = hl;
        @(posedge clk); #1;
        tick = 1'b0; hit = 1'b0; damage = 7'd0; heal = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 7'd0, 1'b0);
    endtask

    task automatic step2(input logic t, input logic h, input logic [6:0] d);
        tick2 = t; hit2 = h; damage2 = d;
        @(posedge clk); #1;
        tick2 = 1'b0; hit2 = 1'b0; damage2 = 7'd0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("rst_health", int'(health), 10);
        check_eq("rst_lives", int'(lives), 3);
        check_eq("rst_invuln", int'(invuln), 0);
        check_eq("rst_dead", int'(dead), 0);
        check_eq("rst_life_lost", int'(life_lost), 0);
        check_eq("rst_hex_tens", int'(hex_tens), int'(SEG_1));
        check_eq("rst_hex_ones", int'(hex_ones), int'(SEG_0));

        // Non-lethal hit opens an 8-tick window.
        step(1'b1, 1'b1, 7'd3, 1'b0);
        check_eq("hit3_health", int'(health), 7);
        check_eq("hit3_invuln", int'(invuln), 1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 7'd3, 1'b0);
        check_eq("inv_ignored_health", int'(health), 7);
        check_eq("inv_still_high", int'(invuln), 1);
        step(1'b1, 1'b1, 7'd3, 1'b0);
        check_eq("inv_end_invuln", int'(invuln), 0);
        check_eq("inv_end_hit_ignored", int'(health), 7);
        step(1'b1, 1'b1, 7'd2, 1'b0);
        check_eq("hit2_health", int'(health), 5);
        ticks(8);
        check_eq("hit2_window_closed", int'(invuln), 0);
        step(1'b0, 1'b1, 7'd2, 1'b0);
        check_eq("no_tick_hit", int'(health), 5);
        step(1'b1, 1'b1, 7'd0, 1'b0);
        check_eq("dmg0_health", int'(health), 5);
        check_eq("dmg0_invuln", int'(invuln), 0);

        // Lethal hit with lives in reserve.
        step(1'b1, 1'b1, 7'd9, 1'b0);
        check_eq("lethal1_life_lost", int'(life_lost), 1);
        check_eq("lethal1_lives", int'(lives), 2);
        check_eq("lethal1_health", int'(health), 10);
        check_eq("lethal1_invuln", int'(invuln), 1);
        step(1'b0, 1'b0, 7'd0, 1'b0);
        check_eq("life_lost_one_cycle", int'(life_lost), 0);
        ticks(8);
        check_eq("lethal1_window_closed", int'(invuln), 0);

        // Heal saturation and simultaneous events.
        step(1'b1, 1'b0, 7'd0, 1'b1);
        check_eq("heal_saturate", int'(health), 10);
        step(1'b1, 1'b1, 7'd4, 1'b0);
        step(1'b1, 1'b0, 7'd0, 1'b1);
        step(1'b1, 1'b0, 7'd0, 1'b1);
        check_eq("two_heals", int'(health), 8);
        step(1'b1, 1'b1, 7'd5, 1'b1);
        check_eq("inv_hit_heal", int'(health), 9);
        check_eq("inv_hit_heal_invuln", int'(invuln), 1);
        ticks(5);
        check_eq("inv_window_closed", int'(invuln), 0);
        step(1'b1, 1'b1, 7'd1, 1'b1);
        check_eq("alive_hit_heal", int'(health), 8);
        ticks(8);

        // Second lethal hit, then the final one (damage equal to health).
        step(1'b1, 1'b1, 7'd9, 1'b0);
        check_eq("lethal2_lives", int'(lives), 1);
        check_eq("lethal2_life_lost", int'(life_lost), 1);
        ticks(8);
        step(1'b1, 1'b1, 7'd10, 1'b0);
        check_eq("death_dead", int'(dead), 1);
        check_eq("death_health", int'(health), 0);
        check_eq("death_lives", int'(lives), 0);
        check_eq("death_no_life_lost", int'(life_lost), 0);
        check_eq("death_invuln", int'(invuln), 0);
        check_eq("death_hex_tens", int'(hex_tens), int'(SEG_0));
        check_eq("death_hex_ones", int'(hex_ones), int'(SEG_0));
        step(1'b1, 1'b1, 7'd5, 1'b1);
        step(1'b1, 1'b0, 7'd0, 1'b1);
        check_eq("dead_hold_health", int'(health), 0);
        check_eq("dead_hold_lives", int'(lives), 0);
        check_eq("dead_hold_dead", int'(dead), 1);

        // Restart from DEAD.
        pulse_restart();
        check_eq("restart_dead_health", int'(health), 10);
        check_eq("restart_dead_lives", int'(lives), 3);
        check_eq("restart_dead_dead", int'(dead), 0);

        // Restart mid-window (counter at 5).
        step(1'b1, 1'b1, 7'd3, 1'b0);
        ticks(3);
        pulse_restart();
        check_eq("restart_inv_health", int'(health), 10);
        check_eq("restart_inv_lives", int'(lives), 3);
        check_eq("restart_inv_invuln", int'(invuln), 0);
        step(1'b1, 1'b1, 7'd1, 1'b0);
        check_eq("post_restart_hit", int'(health), 9);

        // One-cycle reset mid-window.
        ticks(3);
        pulse_reset();
        check_eq("reset_inv_health", int'(health), 10);
        check_eq("reset_inv_lives", int'(lives), 3);
        check_eq("reset_inv_invuln", int'(invuln), 0);

        // Overridden instance: no invulnerability, one life, MAX_HEALTH 25.
        check_eq("d2_rst_health", int'(health2), 25);
        step2(1'b1, 1'b1, 7'd1);
        check_eq("d2_hit_health", int'(health2), 24);
        check_eq("d2_hit_invuln", int'(invuln2), 0);
        check_eq("d2_hex_tens", int'(hex_tens2), int'(SEG_2));
        check_eq("d2_hex_ones", int'(hex_ones2), int'(SEG_4));
        step2(1'b1, 1'b1, 7'd30);
        check_eq("d2_dead", int'(dead2), 1);
        check_eq("d2_dead_health", int'(health2), 0);
        check_eq("d2_dead_lives", int'(lives2), 0);
        check_eq("d2_no_life_lost", int'(life_lost2), 0);
        check_eq("d2_invuln_low", int'(invuln2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/health_tracker.md
Name: health_tracker

Overview:
- Parametrised player-health and lives tracker for the space shooter. It replaces the fixed 10-point, wrap-to-full health counter.
- Adds variable damage, healing, a lives reserve, a post-hit invulnerability window and a sticky death flag.
- Sits between collision detection and the game-control FSM. Events are accepted only on the frame-update strobe.
- Drives two 7-segment digits for on-board display.

Parameters:
- HEALTH_W, 7, width of health and damage values.
- MAX_HEALTH, 10, full-health value. Legal range 1..99; must fit in HEALTH_W.
- LIVES_W, 3, width of the lives counter.
- START_LIVES, 3, lives at reset/restart. Legal range 1..2^LIVES_W-1.
- INVULN_TICKS, 8, frame ticks of invulnerability after any damaging hit. 0 disables invulnerability.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  frame-update strobe. All game events are qualified by it.
- restart  in  1  game-over restart request; same effect as reset.
- hit  in  1  collision event.
- damage  in  HEALTH_W  damage amount for hit.
- heal  in  1  pickup event, +1 health.
- health  out  HEALTH_W  current health.
- lives  out  LIVES_W  lives remaining.
- invuln  out  1  high while hits are ignored.
- life_lost  out  1  one-cycle pulse when a life is consumed.
- dead  out  1  sticky; no lives left.
- hex_ones  out  7  health ones digit, existing decoder7 encoding.
- hex_tens  out  7  health tens digit, existing decoder7 encoding.

Behaviour:
- Reset or restart: highest priority, applied at the next clk edge regardless of tick or state, including mid-invulnerability.
  - health=MAX_HEALTH, lives=START_LIVES, state=ALIVE.
  - invuln counter=0, invuln=0, life_lost=0, dead=0.
- States: ALIVE, INVULN, DEAD. invuln=1 exactly in INVULN; dead=1 exactly in DEAD.
- Event gating: hit and heal are ignored when tick=0. All updates are registered, so outputs reflect an event one cycle after the tick edge.
- ALIVE, tick & hit & damage≠0:
  - Non-lethal (damage<health): health-=damage.
  - Lethal (damage≥health), lives>1: lives-=1, health=MAX_HEALTH, life_lost=1 for one cycle.
  - Lethal, lives==1: lives=0, health=0, go to DEAD.
  - After a non-lethal or lethal-with-respawn hit: if INVULN_TICKS>0, go to INVULN with counter=INVULN_TICKS; otherwise stay in ALIVE.
- Hit with damage=0: no change and no invulnerability.
- Heal in ALIVE or INVULN, tick & heal: health=min(health+1, MAX_HEALTH). Saturates; never wraps.
- Simultaneous events:
  - ALIVE, hit & heal on the same tick: hit wins, heal is dropped.
  - INVULN, hit & heal on the same tick: hit is ignored, heal is applied.
- INVULN: each tick decrements the counter. When a tick arrives with counter==1, counter becomes 0 and the state returns to ALIVE. A hit on that same tick is still ignored.
- DEAD: health, lives and dead are held and all events are ignored until reset or restart.
- Subtraction is evaluated at HEALTH_W+1 bits. No underflow is possible because lethal damage clamps health.
- Display:
  - Tens digit = health/10, ones digit = health%10. Combinational from the health register.
  - Each digit is fed through a decoder7 instance.
  - Health above 99 is illegal by parameter constraint.
- life_lost is never asserted on entry to DEAD.

Test Plan:
- Reset with defaults → health=10, lives=3, invuln=0, dead=0; hex digits show 1 and 0.
- tick+hit damage=3 → health=7, invuln=1. Hits on the next 7 ticks are ignored. After the 8th tick invuln=0. Next hit damage=2 → health=5. Hit with tick=0 → no change.
- health=5, damage=9 → life_lost pulses for exactly one cycle, lives=2, health=10, invuln=1. Repeat twice more → dead=1, health=0, lives=0, no life_lost on the final hit. Further hit and heal events leave all outputs unchanged.
- health=10, tick+heal → stays 10. After damage=4, two heals → 8. In ALIVE, hit+heal on the same tick with damage=1 → health-1 only. In INVULN, hit+heal on the same tick → health+1.
- Mid-INVULN (counter=5), assert restart with tick=0 → next cycle health=10, lives=3, invuln=0. Same result from DEAD. Synchronous reset asserted for one cycle behaves identically.
- Override INVULN_TICKS=0, MAX_HEALTH=25, START_LIVES=1:
  - hit damage=1 → health=24, invuln never rises; digits show 2 and 4.
  - hit damage=30 → dead=1.
